// File: rtl/berzerk_rom_loader.sv
// HPS ROM download sequencer for the Berzerk core: region decode, write strobes,
// post-download / user reset hold, and download status (count, checksum, overflow).
module berzerk_rom_loader #(
  parameter int PROG_BYTES  = 16384,
  parameter int SPCH_BYTES  = 4096,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ext_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        prog_wr,
  output logic        spch_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        overflow,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [24:0]   PROG_END  = 25'(PROG_BYTES);
  localparam logic [24:0]   SPCH_END  = 25'(PROG_BYTES + SPCH_BYTES);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic          prog_wr_r, prog_wr_nxt_s;
  logic          spch_wr_r, spch_wr_nxt_s;
  logic [15:0]   rom_addr_r, rom_addr_nxt_s;
  logic [7:0]    rom_data_r, rom_data_nxt_s;
  logic          core_reset_r;
  logic          load_done_r, load_done_nxt_s;
  logic          overflow_r, overflow_nxt_s;
  logic [16:0]   byte_count_r, byte_count_nxt_s;
  logic [7:0]    checksum_r, checksum_nxt_s;
  logic          accept_s;

  // Next-state, hold counter and write-decode logic.
  always_comb begin
    state_nxt_s      = state_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    prog_wr_nxt_s    = 1'b0;
    spch_wr_nxt_s    = 1'b0;
    rom_addr_nxt_s   = rom_addr_r;
    rom_data_nxt_s   = rom_data_r;
    load_done_nxt_s  = load_done_r;
    overflow_nxt_s   = overflow_r;
    byte_count_nxt_s = byte_count_r;
    checksum_nxt_s   = checksum_r;
    accept_s         = 1'b0;

    case (state_r)
      ST_HOLD: begin
        if (ioctl_download) begin
          state_nxt_s      = ST_LOAD;
          byte_count_nxt_s = 17'd0;
          checksum_nxt_s   = 8'd0;
          overflow_nxt_s   = 1'b0;
        end else if (ext_reset) begin
          hold_cnt_nxt_s = HOLD_INIT;
        end else if (hold_cnt_r <= CNT_ONE) begin
          hold_cnt_nxt_s = CNT_ZERO;
          state_nxt_s    = ST_RUN;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (ioctl_download) begin
          state_nxt_s      = ST_LOAD;
          byte_count_nxt_s = 17'd0;
          checksum_nxt_s   = 8'd0;
          overflow_nxt_s   = 1'b0;
        end else if (ext_reset) begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = HOLD_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        // The last write may coincide with ioctl_download falling; decode it anyway.
        if (ioctl_wr) begin
          if (ioctl_addr < PROG_END) begin
            prog_wr_nxt_s  = 1'b1;
            rom_addr_nxt_s = ioctl_addr[15:0];
            rom_data_nxt_s = ioctl_dout;
            accept_s       = 1'b1;
          end else if (ioctl_addr < SPCH_END) begin
            spch_wr_nxt_s  = 1'b1;
            rom_addr_nxt_s = ioctl_addr[15:0] - PROG_END[15:0];
            rom_data_nxt_s = ioctl_dout;
            accept_s       = 1'b1;
          end else begin
            overflow_nxt_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
        if (accept_s) begin
          checksum_nxt_s = checksum_r + ioctl_dout;
          if (byte_count_r != 17'h1FFFF) begin
            byte_count_nxt_s = byte_count_r + 17'd1;
          end else begin
            byte_count_nxt_s = byte_count_r;
          end
        end else begin
          checksum_nxt_s = checksum_r;
        end
        if (!ioctl_download) begin
          state_nxt_s     = ST_HOLD;
          hold_cnt_nxt_s  = HOLD_INIT;
          load_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: begin
        state_nxt_s    = ST_HOLD;
        hold_cnt_nxt_s = HOLD_INIT;
      end
    endcase
  end

  // State and output registers; core_reset follows the next state so it is registered.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= ST_HOLD;
      hold_cnt_r   <= HOLD_INIT;
      prog_wr_r    <= 1'b0;
      spch_wr_r    <= 1'b0;
      rom_addr_r   <= 16'd0;
      rom_data_r   <= 8'd0;
      core_reset_r <= 1'b1;
      load_done_r  <= 1'b0;
      overflow_r   <= 1'b0;
      byte_count_r <= 17'd0;
      checksum_r   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      prog_wr_r    <= prog_wr_nxt_s;
      spch_wr_r    <= spch_wr_nxt_s;
      rom_addr_r   <= rom_addr_nxt_s;
      rom_data_r   <= rom_data_nxt_s;
      core_reset_r <= (state_nxt_s != ST_RUN);
      load_done_r  <= load_done_nxt_s;
      overflow_r   <= overflow_nxt_s;
      byte_count_r <= byte_count_nxt_s;
      checksum_r   <= checksum_nxt_s;
    end
  end

  assign prog_wr    = prog_wr_r;
  assign spch_wr    = spch_wr_r;
  assign rom_addr   = rom_addr_r;
  assign rom_data   = rom_data_r;
  assign core_reset = core_reset_r;
  assign load_done  = load_done_r;
  assign overflow   = overflow_r;
  assign byte_count = byte_count_r;
  assign checksum   = checksum_r;

endmodule

// File: tb/tb_berzerk_rom_loader.sv
// Randomized bench for berzerk_rom_loader: every cycle the DUT outputs are compared
// against a download/hold reference model kept here.
module tb_berzerk_rom_loader;

  localparam int PROG = 16384;
  localparam int SPCH = 4096;
  localparam int HOLD = 64;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ext_reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        prog_wr, spch_wr, core_reset, load_done, overflow;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, checksum;
  logic [16:0] byte_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_loading, m_done, m_ovf, m_pw, m_sw;
  int m_remain, m_cnt, m_sum, m_addr, m_data;

  berzerk_rom_loader #(.PROG_BYTES(PROG), .SPCH_BYTES(SPCH), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ext_reset(ext_reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .prog_wr(prog_wr), .spch_wr(spch_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_reset(core_reset), .load_done(load_done), .overflow(overflow),
    .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_pw = 1'b0; m_sw = 1'b0;
    m_remain = HOLD; m_cnt = 0; m_sum = 0; m_addr = 0; m_data = 0;
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int a;
    bit was_loading;
    was_loading = m_loading;
    a = int'(ioctl_addr);
    m_pw = 1'b0;
    m_sw = 1'b0;
    if (was_loading && ioctl_wr) begin
      if (a < PROG || a < PROG + SPCH) begin
        if (a < PROG) begin
          m_pw = 1'b1; m_addr = a;
        end else begin
          m_sw = 1'b1; m_addr = (a - PROG) % 65536;
        end
        m_data = int'(ioctl_dout);
        m_sum = (m_sum + int'(ioctl_dout)) % 256;
        if (m_cnt < 'h1FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (ioctl_download) begin
      if (!was_loading) begin
        m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
      end
      m_loading = 1'b1;
    end else if (was_loading) begin
      m_loading = 1'b0; m_remain = HOLD; m_done = 1'b1;
    end else if (ext_reset) begin
      m_remain = HOLD;
    end else if (m_remain > 0) begin
      m_remain = m_remain - 1;
    end
  endtask

  task automatic compare_all();
    check("prog_wr",    prog_wr,    32'(m_pw));
    check("spch_wr",    spch_wr,    32'(m_sw));
    check("rom_addr",   rom_addr,   32'(m_addr));
    check("rom_data",   rom_data,   32'(m_data));
    check("core_reset", core_reset, 32'(m_loading || m_remain > 0));
    check("load_done",  load_done,  32'(m_done));
    check("overflow",   overflow,   32'(m_ovf));
    check("byte_count", byte_count, 32'(m_cnt));
    check("checksum",   checksum,   32'(m_sum));
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic tick();
    model_step();
    @(negedge clk_sys);
    compare_all();
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_dout = data;
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  function automatic logic [24:0] rand_addr();
    logic [24:0] a;
    case ($urandom_range(0, 4))
      0: a = 25'($urandom_range(0, PROG - 1));
      1: a = 25'(PROG + $urandom_range(0, SPCH - 1));
      2: a = 25'($urandom_range(PROG + SPCH, 32767));
      3: begin
        case ($urandom_range(0, 3))
          0: a = 25'(PROG - 1);
          1: a = 25'(PROG);
          2: a = 25'(PROG + SPCH - 1);
          default: a = 25'(PROG + SPCH);
        endcase
      end
      default: a = 25'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    int idle;
    int n;
    reset = 1'b1; ext_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    model_reset();
    repeat (2) @(negedge clk_sys);
    compare_all();
    reset = 1'b0;

    // Power-on hold: core_reset high for exactly HOLD cycles
    repeat (70) tick();
    check("por_run", core_reset, 32'd0);

    // Program ROM download
    start_dl();
    wr_byte(25'h0000000, 8'h12);
    wr_byte(25'h0000001, 8'h34);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0003FFF; ioctl_dout = 8'h56;
    tick();
    check("prog_last_addr", rom_addr, 32'h3FFF);
    ioctl_wr = 1'b0;
    tick();
    check("dir_count", byte_count, 32'd3);
    check("dir_csum", checksum, 32'h9C);
    end_dl();
    check("dir_done", load_done, 32'd1);
    repeat (66) tick();

    // Speech region and out-of-range write
    start_dl();
    wr_byte(25'h0004000, 8'hAA);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0004FFF; ioctl_dout = 8'h01;
    tick();
    check("spch_last_addr", rom_addr, 32'h0FFF);
    ioctl_wr = 1'b0;
    tick();
    wr_byte(25'h0005000, 8'h77);
    check("ovf_set", overflow, 32'd1);
    check("ovf_count", byte_count, 32'd2);
    end_dl();
    repeat (10) tick();
    start_dl();
    check("ovf_clear", overflow, 32'd0);
    ext_reset = 1'b1;
    repeat (3) tick();
    ext_reset = 1'b0;
    wr_byte(25'h1000000, 8'h5A);
    end_dl();
    repeat (70) tick();

    // ext_reset pulsed in RUN
    ext_reset = 1'b1;
    repeat (3) tick();
    ext_reset = 1'b0;
    repeat (70) tick();

    // Download starting mid-hold
    start_dl();
    wr_byte(25'h0000010, 8'hC3);
    end_dl();
    repeat (20) tick();
    start_dl();
    wr_byte(25'h0004321, 8'h3C);
    end_dl();
    repeat (66) tick();

    // Final write coincident with ioctl_download falling
    start_dl();
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'hE7;
    ioctl_download = 1'b0;
    tick();
    check("coinc_strobe", prog_wr, 32'd1);
    check("coinc_addr", rom_addr, 32'd5);
    ioctl_wr = 1'b0;
    repeat (66) tick();

    // Async reset mid-download with a write in flight
    start_dl();
    wr_byte(25'h0000020, 8'h11);
    ioctl_wr = 1'b1; ioctl_addr = 25'd7; ioctl_dout = 8'h33;
    #2 reset = 1'b1;
    #1;
    check("arst_core_reset", core_reset, 32'd1);
    check("arst_count", byte_count, 32'd0);
    check("arst_done", load_done, 32'd0);
    model_reset();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    compare_all();
    reset = 1'b0;
    repeat (30) tick();

    // Randomized downloads with ext_reset noise
    for (int k = 0; k < 25; k++) begin
      idle = $urandom_range(0, 90);
      for (int i = 0; i < idle; i++) begin
        ext_reset = ($urandom_range(0, 15) == 0);
        tick();
      end
      ext_reset = 1'b0;
      start_dl();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        ext_reset = ($urandom_range(0, 3) == 0);
        ioctl_wr = 1'b1; ioctl_addr = rand_addr(); ioctl_dout = 8'($urandom);
        if (i == n - 1 && $urandom_range(0, 1) == 1) begin
          ioctl_download = 1'b0;
          tick();
          ioctl_wr = 1'b0;
        end else begin
          tick();
          ioctl_wr = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      if (ioctl_download) end_dl();
      ext_reset = 1'b0;
    end
    repeat (70) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/berzerk_rom_loader.md
Name: berzerk_rom_loader

Overview:
- Sequences the HPS ROM download into the Berzerk core and owns core reset sequencing.
- Decodes the linear download address into the program-ROM and speech-ROM regions and issues one-cycle write strobes with region-local addresses.
- Holds the core in reset during a download and for a programmable number of cycles after it; the same hold applies after a user or menu reset.
- Tracks byte count, an 8-bit checksum and an overflow error for status/debug.

Parameters:
- PROG_BYTES, 16384: size of the program ROM region, starting at download address 0.
- SPCH_BYTES, 4096: size of the speech ROM region, starting at PROG_BYTES.
- HOLD_CYCLES, 64: number of clk_sys cycles core_reset stays high after a download ends or ext_reset falls. Minimum 1.

Ports:
- clk_sys  in  1  system clock (40 MHz)
- reset  in  1  asynchronous, active-high reset
- ext_reset  in  1  user/menu reset request (status[0] | buttons[1]), synchronous level
- ioctl_download  in  1  download-active level
- ioctl_wr  in  1  one-cycle write pulse
- ioctl_addr  in  25  linear byte address
- ioctl_dout  in  8  download byte
- prog_wr  out  1  program ROM write strobe
- spch_wr  out  1  speech ROM write strobe
- rom_addr  out  16  region-local byte address
- rom_data  out  8  byte to write
- core_reset  out  1  reset to the core
- load_done  out  1  at least one download has completed since reset
- overflow  out  1  sticky: a write fell outside both regions during the current/last download
- byte_count  out  17  accepted bytes in the current/last download, saturating at 17'h1FFFF
- checksum  out  8  modulo-256 sum of accepted bytes

Behaviour:
- Reset values:
  - prog_wr=0, spch_wr=0, rom_addr=0, rom_data=0.
  - core_reset=1, load_done=0, overflow=0, byte_count=0, checksum=0.
  - State=HOLD, hold counter=HOLD_CYCLES.
- All outputs are registered. Asynchronous reset has priority over every transition.
- States: HOLD, RUN, LOAD.
- HOLD:
  - core_reset=1.
  - If ioctl_download=1, go to LOAD.
  - Otherwise, if ext_reset=1, reload the counter to HOLD_CYCLES.
  - Otherwise, decrement the counter. On the cycle the counter reaches 0, go to RUN.
  - With no further events, core_reset is high for exactly HOLD_CYCLES cycles after entry.
- RUN:
  - core_reset=0.
  - If ioctl_download=1, go to LOAD; core_reset=1 on the next cycle.
  - Else if ext_reset=1, go to HOLD, reload the counter, core_reset=1 on the next cycle.
  - ioctl_download has priority over ext_reset.
- LOAD:
  - core_reset=1.
  - On entry (the first cycle ioctl_download is seen high from HOLD or RUN), clear byte_count, checksum and overflow.
  - On ioctl_download=0, go to HOLD, reload the counter to HOLD_CYCLES, and set load_done=1.
  - ext_reset is ignored while in LOAD.
- Write decode applies in LOAD only. ioctl_wr outside LOAD is ignored.
  - Strobe latency is 1 cycle: an ioctl_wr at cycle N gives prog_wr or spch_wr =1 at N+1 for exactly one cycle, with rom_addr and rom_data valid in the same cycle.
  - ioctl_addr < PROG_BYTES: prog_wr, rom_addr=ioctl_addr[15:0].
  - PROG_BYTES <= ioctl_addr < PROG_BYTES+SPCH_BYTES: spch_wr, rom_addr=ioctl_addr-PROG_BYTES (truncated to 16 bits).
  - Compare addresses at the full 25 bits. Any ioctl_addr bit above the region range set means out of range.
  - Out of range: no strobe, overflow<=1, byte_count and checksum unchanged.
  - Accepted write: byte_count+1 (saturating), checksum+ioctl_dout (wraps mod 256).
  - rom_addr and rom_data hold their last value when no strobe is issued.
- Simultaneous events:
  - A final ioctl_wr in the same cycle ioctl_download falls is still decoded and strobed.
  - A new download starting in HOLD aborts the hold and restarts the counter when it ends.
- prog_wr and spch_wr are never high in the same cycle.

Test Plan:
- Power-on: pulse reset, then idle -> core_reset high for exactly 64 cycles after reset release, then 0; load_done=0; all strobes 0.
- Download of 3 bytes 0x12,0x34,0x56 at addresses 0,1,0x3FFF -> prog_wr pulses one cycle after each ioctl_wr with rom_addr 0,1,0x3FFF; byte_count=3, checksum=0x9C. After ioctl_download falls: load_done=1, core_reset falls 64 cycles later.
- Writes at addresses 0x4000 (0xAA) and 0x4FFF (0x01) -> spch_wr with rom_addr 0x0000 and 0x0FFF. Write at 0x5000 -> no strobe, overflow=1, byte_count unchanged. A new download start clears overflow to 0.
- ext_reset pulsed 3 cycles in RUN -> core_reset high from the next cycle until 64 cycles after ext_reset falls. ext_reset asserted during LOAD -> no effect on state.
- Download starting mid-HOLD and mid-RUN, plus async reset asserted mid-LOAD while a write is in flight -> immediately core_reset=1, no strobe, counters cleared, state HOLD.
- ioctl_wr coincident with ioctl_download falling at address 5 -> prog_wr at the next cycle with rom_addr 5; hold countdown starts on that same edge.
